axis_rr_arbiter: RTL and testbench

Packet-aware round-robin arbiter that time-shares one AXI-stream master port among PORT_NUM slave ports. It drives the one-hot `mux_ctrl_i` of the team's `axis_mux`. It watches the same valid/ready/last handshakes so it can hold a grant for a whole packet and rotate fairly between packets. A beat-count watchdog forces release on runaway packets that never assert last.

---
 rtl/axis_rr_arbiter_if.sv | 22 ++
 rtl/axis_rr_arbiter.sv | 70 +++++++
 tb/tb_axis_rr_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/axis_rr_arbiter_if.sv
// axis_rr_arbiter_if: handshake taps and grant outputs shared between the arbiter and its surroundings.
interface axis_rr_arbiter_if #(
    parameter int PORT_NUM = 4
);
    localparam int IW = $clog2(PORT_NUM);
    logic [PORT_NUM-1:0] en_i;
    logic [PORT_NUM-1:0] s_axi_vld_i;
    logic [PORT_NUM-1:0] s_axi_lst_i;
    logic                m_axi_rdy_i;
    logic [PORT_NUM-1:0] mux_ctrl_o;
    logic [IW-1:0]       grant_idx_o;
    logic                busy_o;
    logic                ovf_o;
    modport master (
        input  en_i, s_axi_vld_i, s_axi_lst_i, m_axi_rdy_i,
        output mux_ctrl_o, grant_idx_o, busy_o, ovf_o
    );
    modport slave (
        output en_i, s_axi_vld_i, s_axi_lst_i, m_axi_rdy_i,
        input  mux_ctrl_o, grant_idx_o, busy_o, ovf_o
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-locking round-robin grant for axis_mux, with a beat-count watchdog.
module axis_rr_arbiter #(
    parameter int PORT_NUM  = 4,
    parameter int MAX_BEATS = 256,
    parameter int CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
    input logic clk_i,
    input logic rst_i,
    axis_rr_arbiter_if.master a
);
    localparam int IW = $clog2(PORT_NUM);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t state_q, state_d;
    logic [PORT_NUM-1:0]  grant_q, grant_d, req;
    logic [IW-1:0]        idx_q, idx_d, last_q, last_d, win;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic ovf_q, ovf_d, win_vld, beat, lst, at_max, pkt_end;
    assign req = a.s_axi_vld_i & a.en_i;
    // Scan from farthest to nearest so the nearest requester after last_q wins.
    always_comb begin
        win     = last_q;
        win_vld = 1'b0;
        for (int k = PORT_NUM; k >= 1; k--) begin
            if (req[(int'(last_q) + k) % PORT_NUM]) begin
                win     = IW'((int'(last_q) + k) % PORT_NUM);
                win_vld = 1'b1;
            end
        end
    end
    assign beat    = |(grant_q & a.s_axi_vld_i) & a.m_axi_rdy_i;
    assign lst     = |(grant_q & a.s_axi_lst_i);
    assign at_max  = (cnt_q + 1'b1) == CNT_WIDTH'(MAX_BEATS);
    assign pkt_end = (state_q == LOCK) & beat & (lst | at_max);
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = beat ? cnt_q + 1'b1 : cnt_q;
        ovf_d   = pkt_end & ~lst;
        if (state_q == IDLE || pkt_end) begin
            state_d = win_vld ? LOCK : IDLE;
            grant_d = win_vld ? PORT_NUM'(1) << win : '0;
            idx_d   = win_vld ? win : '0;
            last_d  = win_vld ? win : last_q;
            cnt_d   = '0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IW'(PORT_NUM - 1);
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
    assign a.mux_ctrl_o  = grant_q;
    assign a.grant_idx_o = idx_q;
    assign a.busy_o      = state_q == LOCK;
    assign a.ovf_o       = ovf_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed scenarios plus random traffic, checked every cycle against a packet-level model.
module tb_axis_rr_arbiter;
    localparam int P  = 4;
    localparam int MB = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    axis_rr_arbiter_if #(.PORT_NUM(P)) bus ();
    axis_rr_arbiter #(.PORT_NUM(P), .MAX_BEATS(MB)) dut (.clk_i(clk), .rst_i(rst), .a(bus));
    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;
    int m_g = -1;
    int m_last = P - 1;
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", n, got, exp, $time);
        end
    endtask
    function automatic int pick(input int last, input logic [P-1:0] req);
        for (int k = 1; k <= P; k++)
            if (req[(last + k) % P]) return (last + k) % P;
        return -1;
    endfunction
    // Model: which port owns the output, how many beats it has moved, who goes next.
    always @(posedge clk) begin
        logic [P-1:0] req;
        bit done;
        if (rst) begin
            m_g = -1; m_last = P - 1; m_cnt = 0; m_ovf = 0;
        end else begin
            req = bus.s_axi_vld_i & bus.en_i;
            m_ovf = 0;
            done = 0;
            if (m_g < 0) done = 1;
            else if (bus.s_axi_vld_i[m_g] && bus.m_axi_rdy_i) begin
                m_cnt++;
                done = bus.s_axi_lst_i[m_g] || m_cnt == MB;
                m_ovf = !bus.s_axi_lst_i[m_g] && m_cnt == MB;
            end
            if (done) begin
                m_g = pick(m_last, req);
                if (m_g >= 0) m_last = m_g;
                m_cnt = 0;
            end
        end
    end
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_mux", 32'(bus.mux_ctrl_o), m_g < 0 ? 32'd0 : 32'd1 << m_g);
            chk("model_idx", 32'(bus.grant_idx_o), m_g < 0 ? 32'd0 : 32'(m_g));
            chk("model_busy", 32'(bus.busy_o), 32'(m_g >= 0));
            chk("model_ovf", 32'(bus.ovf_o), 32'(m_ovf));
        end
    end
    task automatic step(input logic [P-1:0] e, input logic [P-1:0] v, input logic [P-1:0] l,
                        input logic r, input logic rs);
        bus.en_i = e;
        bus.s_axi_vld_i = v;
        bus.s_axi_lst_i = l;
        bus.m_axi_rdy_i = r;
        rst = rs;
        @(negedge clk);
    endtask
    initial begin
        bus.en_i = '0;
        bus.s_axi_vld_i = '0;
        bus.s_axi_lst_i = '0;
        bus.m_axi_rdy_i = 1'b0;
        @(negedge clk);
        step(4'hF, 4'b1111, 4'b0000, 1, 1);
        chk_on = 1'b1;
        chk("rst_mux", 32'(bus.mux_ctrl_o), 0);
        chk("rst_idx", 32'(bus.grant_idx_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_ovf", 32'(bus.ovf_o), 0);
        // Single requester: port 2, three beats; its enable drops on the last beat.
        step(4'hF, 4'b0100, 4'b0000, 1, 0);
        chk("single_grant", 32'(bus.mux_ctrl_o), 32'b0100);
        chk("single_idx", 32'(bus.grant_idx_o), 2);
        step(4'hF, 4'b0100, 4'b0000, 1, 0);
        step(4'hF, 4'b0100, 4'b0000, 1, 0);
        chk("single_hold", 32'(bus.mux_ctrl_o), 32'b0100);
        step(4'b1011, 4'b0100, 4'b0100, 1, 0);
        chk("single_release", 32'(bus.mux_ctrl_o), 0);
        chk("single_idle_busy", 32'(bus.busy_o), 0);
        // Watchdog: port 0 runs past MAX_BEATS while port 3 waits.
        step(4'hF, 4'b0001, 4'b0000, 1, 0);
        for (int i = 0; i < MB; i++) step(4'hF, 4'b1001, 4'b0000, 1, 0);
        chk("wd_ovf", 32'(bus.ovf_o), 1);
        chk("wd_move", 32'(bus.mux_ctrl_o), 32'b1000);
        chk("wd_idx", 32'(bus.grant_idx_o), 3);
        step(4'hF, 4'b1001, 4'b1000, 1, 0);
        chk("wd_pulse_end", 32'(bus.ovf_o), 0);
        chk("wd_back0", 32'(bus.mux_ctrl_o), 32'b0001);
        for (int i = 0; i < MB - 1; i++) step(4'hF, 4'b1001, 4'b0000, 1, 0);
        step(4'hF, 4'b1001, 4'b0001, 1, 0);
        chk("wd_last_no_ovf", 32'(bus.ovf_o), 0);
        chk("wd_last_move", 32'(bus.mux_ctrl_o), 32'b1000);
        // Reset mid-packet, then ports 0 and 2 compete.
        step(4'hF, 4'b1000, 4'b0000, 1, 0);
        step(4'hF, 4'b1000, 4'b0000, 1, 1);
        chk("midrst_mux", 32'(bus.mux_ctrl_o), 0);
        chk("midrst_busy", 32'(bus.busy_o), 0);
        chk("midrst_ovf", 32'(bus.ovf_o), 0);
        step(4'hF, 4'b0101, 4'b0000, 1, 0);
        chk("midrst_port0", 32'(bus.mux_ctrl_o), 32'b0001);
        for (int i = 0; i < 4000; i++)
            step($urandom_range(3) == 0 ? 4'($urandom) : 4'hF, 4'($urandom), 4'($urandom & $urandom),
                 $urandom_range(3) != 0, $urandom_range(249) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
